conv_rd_arb: RTL and testbench

Read-channel arbiter sharing the single bus/DDR3 read port between the image-read requester and the filter-read requester of the convolution engine. It serialises the two address streams onto the bus AR channel with round-robin arbitration, tags each burst with a per-requester ID, and caps outstanding bursts per requester. It demultiplexes returning read data by `rid`, so image and filter pixels can be fetched concurrently instead of by address-bit steering.

---
 rtl/conv_rd_arb.sv | 157 +++++++++++++++
 tb/tb_conv_rd_arb.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_rd_arb.sv
// rtl/conv_rd_arb.sv - round-robin read-channel arbiter between image and filter requesters
// Serialises two AR streams onto one bus port, tags by ID, caps outstanding bursts, routes R by rid.
module conv_rd_arb #(
  parameter logic [3:0]  ID_IMG   = 4'h1,
  parameter logic [3:0]  ID_FLT   = 4'h2,
  parameter int unsigned MAX_OUTS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        img_arvalid,
  input  logic [27:0] img_araddr,
  input  logic [3:0]  img_arlen,
  input  logic        img_aruserap,
  output logic        img_arready,
  input  logic        flt_arvalid,
  input  logic [27:0] flt_araddr,
  input  logic [3:0]  flt_arlen,
  input  logic        flt_aruserap,
  output logic        flt_arready,
  output logic        img_rvalid,
  output logic        img_rlast,
  output logic [31:0] img_rdata,
  output logic        flt_rvalid,
  output logic        flt_rlast,
  output logic [31:0] flt_rdata,
  input  logic        BusArb_arready,
  input  logic        BusArb_rvalid,
  input  logic        BusArb_rlast,
  input  logic [3:0]  BusArb_rid,
  input  logic [31:0] BusArb_rdata,
  output logic        ArbBus_arvalid,
  output logic [3:0]  ArbBus_arusrid,
  output logic [3:0]  ArbBus_arlen,
  output logic        ArbBus_aruserap,
  output logic [27:0] ArbBus_araddr,
  output logic        rid_err,
  output logic        busy
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [2:0] CAP = 3'(MAX_OUTS);

  state_t     state;
  logic       last_flt;
  logic       issue_flt;
  logic [2:0] outs_img;
  logic [2:0] outs_flt;

  logic img_elig, flt_elig;
  logic grant_img, grant_flt;
  logic handshake;
  logic hit_img, hit_flt, hit_bad;
  logic end_img, end_flt;
  logic inc_img, inc_flt, dec_img, dec_flt;
  logic underflow;

  assign img_elig  = img_arvalid && (outs_img < CAP);
  assign flt_elig  = flt_arvalid && (outs_flt < CAP);
  // On a tie the requester that did not win last time goes first.
  assign grant_img = (state == IDLE) && img_elig && (!flt_elig || last_flt);
  assign grant_flt = (state == IDLE) && flt_elig && !grant_img;

  assign img_arready = grant_img;
  assign flt_arready = grant_flt;

  assign handshake = (state == ISSUE) && BusArb_arready;

  assign hit_img = BusArb_rvalid && (BusArb_rid == ID_IMG);
  assign hit_flt = BusArb_rvalid && (BusArb_rid == ID_FLT);
  assign hit_bad = BusArb_rvalid && !hit_img && !hit_flt;
  assign end_img = hit_img && BusArb_rlast;
  assign end_flt = hit_flt && BusArb_rlast;

  assign inc_img   = handshake && !issue_flt;
  assign inc_flt   = handshake && issue_flt;
  assign dec_img   = end_img && (outs_img != 3'd0);
  assign dec_flt   = end_flt && (outs_flt != 3'd0);
  assign underflow = (end_img && (outs_img == 3'd0)) || (end_flt && (outs_flt == 3'd0));

  assign busy = (state == ISSUE) || (outs_img != 3'd0) || (outs_flt != 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_flt        <= 1'b1;
      issue_flt       <= 1'b0;
      ArbBus_arvalid  <= 1'b0;
      ArbBus_arusrid  <= 4'h0;
      ArbBus_arlen    <= 4'h0;
      ArbBus_aruserap <= 1'b0;
      ArbBus_araddr   <= 28'h0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_img || grant_flt) begin
            state           <= ISSUE;
            last_flt        <= grant_flt;
            issue_flt       <= grant_flt;
            ArbBus_arvalid  <= 1'b1;
            ArbBus_arusrid  <= grant_flt ? ID_FLT : ID_IMG;
            ArbBus_arlen    <= grant_flt ? flt_arlen : img_arlen;
            ArbBus_aruserap <= grant_flt ? flt_aruserap : img_aruserap;
            ArbBus_araddr   <= grant_flt ? flt_araddr : img_araddr;
          end
        end
        ISSUE: begin
          if (BusArb_arready) begin
            state          <= IDLE;
            ArbBus_arvalid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A same-cycle increment and decrement cancel out; a decrement at zero is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outs_img <= 3'd0;
      outs_flt <= 3'd0;
    end else begin
      case ({inc_img, dec_img})
        2'b10:   outs_img <= outs_img + 3'd1;
        2'b01:   outs_img <= outs_img - 3'd1;
        default: outs_img <= outs_img;
      endcase
      case ({inc_flt, dec_flt})
        2'b10:   outs_flt <= outs_flt + 3'd1;
        2'b01:   outs_flt <= outs_flt - 3'd1;
        default: outs_flt <= outs_flt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_rvalid <= 1'b0;
      img_rlast  <= 1'b0;
      img_rdata  <= 32'h0;
      flt_rvalid <= 1'b0;
      flt_rlast  <= 1'b0;
      flt_rdata  <= 32'h0;
      rid_err    <= 1'b0;
    end else begin
      img_rvalid <= hit_img;
      img_rlast  <= end_img;
      flt_rvalid <= hit_flt;
      flt_rlast  <= end_flt;
      if (hit_img) img_rdata <= BusArb_rdata;
      if (hit_flt) flt_rdata <= BusArb_rdata;
      if (hit_bad || underflow) rid_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_rd_arb.sv
// tb/tb_conv_rd_arb.sv - directed self-checking bench for conv_rd_arb
// Inputs change at posedge+1, outputs are sampled at posedge+2.
module tb_conv_rd_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        img_arvalid, flt_arvalid;
  logic [27:0] img_araddr, flt_araddr;
  logic [3:0]  img_arlen, flt_arlen;
  logic        img_aruserap, flt_aruserap;
  logic        img_arready, flt_arready;
  logic        img_rvalid, img_rlast, flt_rvalid, flt_rlast;
  logic [31:0] img_rdata, flt_rdata;
  logic        BusArb_arready, BusArb_rvalid, BusArb_rlast;
  logic [3:0]  BusArb_rid;
  logic [31:0] BusArb_rdata;
  logic        ArbBus_arvalid;
  logic [3:0]  ArbBus_arusrid, ArbBus_arlen;
  logic        ArbBus_aruserap;
  logic [27:0] ArbBus_araddr;
  logic        rid_err, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  conv_rd_arb dut (
    .clk(clk), .rst_n(rst_n),
    .img_arvalid(img_arvalid), .img_araddr(img_araddr), .img_arlen(img_arlen),
    .img_aruserap(img_aruserap), .img_arready(img_arready),
    .flt_arvalid(flt_arvalid), .flt_araddr(flt_araddr), .flt_arlen(flt_arlen),
    .flt_aruserap(flt_aruserap), .flt_arready(flt_arready),
    .img_rvalid(img_rvalid), .img_rlast(img_rlast), .img_rdata(img_rdata),
    .flt_rvalid(flt_rvalid), .flt_rlast(flt_rlast), .flt_rdata(flt_rdata),
    .BusArb_arready(BusArb_arready), .BusArb_rvalid(BusArb_rvalid),
    .BusArb_rlast(BusArb_rlast), .BusArb_rid(BusArb_rid), .BusArb_rdata(BusArb_rdata),
    .ArbBus_arvalid(ArbBus_arvalid), .ArbBus_arusrid(ArbBus_arusrid),
    .ArbBus_arlen(ArbBus_arlen), .ArbBus_aruserap(ArbBus_aruserap),
    .ArbBus_araddr(ArbBus_araddr), .rid_err(rid_err), .busy(busy)
  );

  task automatic clear_inputs();
    img_arvalid = 0; img_araddr = '0; img_arlen = '0; img_aruserap = 0;
    flt_arvalid = 0; flt_araddr = '0; flt_arlen = '0; flt_aruserap = 0;
    BusArb_arready = 0; BusArb_rvalid = 0; BusArb_rlast = 0;
    BusArb_rid = '0; BusArb_rdata = '0;
  endtask

  // Leaves the bench at posedge+1 with reset released.
  task automatic apply_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [81:0] outs;
    clear_inputs();
    rst_n = 0;
    #1;
    outs = {img_arready, flt_arready, img_rvalid, img_rlast, img_rdata, flt_rvalid, flt_rlast,
            ArbBus_arvalid, ArbBus_arusrid, ArbBus_arlen, ArbBus_aruserap, ArbBus_araddr,
            rid_err, busy};
    n_cmp++;
    if (outs !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    n_cmp++;
    if (flt_rdata !== 32'h0) begin
      n_bad++; $display("FAIL reset_flt_rdata: got %h expected 0", flt_rdata);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_single_img();
    logic [37:0] exp_f;
    exp_f = {1'b1, 4'h1, 4'hF, 1'b1, 28'h0000100};
    apply_reset();
    img_arvalid = 1; img_araddr = 28'h0000100; img_arlen = 4'd15; img_aruserap = 1;
    #1;
    n_cmp++;
    if ({img_arready, flt_arready, ArbBus_arvalid} !== 3'b100) begin
      n_bad++; $display("FAIL single_grant: got %b expected 100", {img_arready, flt_arready, ArbBus_arvalid});
    end
    next_cycle();
    img_arvalid = 0; img_araddr = 28'hFFFFFFF; img_arlen = 4'h3; img_aruserap = 0;
    for (int j = 0; j < 3; j++) begin
      #1;
      n_cmp++;
      if ({ArbBus_arvalid, ArbBus_arusrid, ArbBus_arlen, ArbBus_aruserap, ArbBus_araddr} !== exp_f) begin
        n_bad++;
        $display("FAIL single_fields_c%0d: got %h expected %h", j,
                 {ArbBus_arvalid, ArbBus_arusrid, ArbBus_arlen, ArbBus_aruserap, ArbBus_araddr}, exp_f);
      end
      next_cycle();
    end
    BusArb_arready = 1;
    #1;
    n_cmp++;
    if ({ArbBus_arvalid, ArbBus_arusrid, ArbBus_arlen, ArbBus_aruserap, ArbBus_araddr} !== exp_f) begin
      n_bad++; $display("FAIL single_fields_hs: got %h expected %h",
                        {ArbBus_arvalid, ArbBus_arusrid, ArbBus_arlen, ArbBus_aruserap, ArbBus_araddr}, exp_f);
    end
    next_cycle();
    BusArb_arready = 0;
    #1;
    n_cmp++;
    if ({ArbBus_arvalid, busy} !== 2'b01) begin
      n_bad++; $display("FAIL single_after_hs: got arvalid,busy=%b expected 01", {ArbBus_arvalid, busy});
    end
    next_cycle();
    BusArb_rvalid = 1; BusArb_rlast = 1; BusArb_rid = 4'h1; BusArb_rdata = 32'hA5A5_0001;
    next_cycle();
    BusArb_rvalid = 0; BusArb_rlast = 0;
    #1;
    n_cmp++;
    if ({img_rvalid, img_rlast, flt_rvalid, img_rdata} !== {3'b110, 32'hA5A5_0001}) begin
      n_bad++; $display("FAIL single_rbeat: got %h expected %h",
                        {img_rvalid, img_rlast, flt_rvalid, img_rdata}, {3'b110, 32'hA5A5_0001});
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL single_busy_clear: got %b expected 0", busy);
    end
    next_cycle();
    #1;
    n_cmp++;
    if ({img_rvalid, img_rdata} !== {1'b0, 32'hA5A5_0001}) begin
      n_bad++; $display("FAIL single_rdata_hold: got %h expected %h", {img_rvalid, img_rdata}, {1'b0, 32'hA5A5_0001});
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_id;
    apply_reset();
    BusArb_arready = 1;
    img_arvalid = 1; img_araddr = 28'h0001000;
    flt_arvalid = 1; flt_araddr = 28'h0002000;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++;
      if ({img_arready, flt_arready, ArbBus_arvalid} !== {(i % 4) == 0, (i % 4) == 2, (i % 2) == 1}) begin
        n_bad++; $display("FAIL rr_cycle%0d: got rdy_i,rdy_f,arvalid=%b expected %b", i,
                          {img_arready, flt_arready, ArbBus_arvalid}, {(i % 4) == 0, (i % 4) == 2, (i % 2) == 1});
      end
      if (i % 2 == 1) begin
        exp_id = ((i >> 1) & 1) == 0 ? 4'h1 : 4'h2;
        n_cmp++;
        if (ArbBus_arusrid !== exp_id) begin
          n_bad++; $display("FAIL rr_id%0d: got %h expected %h", i, ArbBus_arusrid, exp_id);
        end
      end
      next_cycle();
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_outs_cap();
    int grants = 0;
    int addrs = 0;
    apply_reset();
    BusArb_arready = 1;
    img_arvalid = 1; img_araddr = 28'h0003000;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (img_arready) grants++;
      if (ArbBus_arvalid) addrs++;
      next_cycle();
    end
    n_cmp++;
    if (grants !== 4) begin
      n_bad++; $display("FAIL cap_grants: got %0d expected 4", grants);
    end
    n_cmp++;
    if (addrs !== 4) begin
      n_bad++; $display("FAIL cap_addrs: got %0d expected 4", addrs);
    end
    BusArb_rvalid = 1; BusArb_rlast = 1; BusArb_rid = 4'h1; BusArb_rdata = 32'h0000_0C0D;
    #1;
    n_cmp++;
    if (img_arready !== 1'b0) begin
      n_bad++; $display("FAIL cap_blocked_K: got %b expected 0", img_arready);
    end
    next_cycle();
    BusArb_rvalid = 0; BusArb_rlast = 0;
    #1;
    n_cmp++;
    if ({img_arready, img_rvalid, img_rlast} !== 3'b111) begin
      n_bad++; $display("FAIL cap_regrant_K1: got %b expected 111", {img_arready, img_rvalid, img_rlast});
    end
    next_cycle();
    img_arvalid = 0;
    #1;
    n_cmp++;
    if (ArbBus_arvalid !== 1'b1) begin
      n_bad++; $display("FAIL cap_fifth_addr: got %b expected 1", ArbBus_arvalid);
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_interleaved();
    int p;
    apply_reset();
    BusArb_arready = 1;
    img_arvalid = 1; flt_arvalid = 1;
    next_cycle();
    img_arvalid = 0;
    next_cycle();
    next_cycle();
    flt_arvalid = 0;
    next_cycle();
    BusArb_arready = 0;
    #1;
    n_cmp++;
    if ({busy, ArbBus_arvalid} !== 2'b10) begin
      n_bad++; $display("FAIL il_setup: got busy,arvalid=%b expected 10", {busy, ArbBus_arvalid});
    end
    for (int i = 0; i <= 32; i++) begin
      if (i < 32) begin
        BusArb_rvalid = 1; BusArb_rid = (i < 16) ? 4'h2 : 4'h1;
        BusArb_rlast = (i == 15) || (i == 31); BusArb_rdata = i;
      end else begin
        BusArb_rvalid = 0; BusArb_rlast = 0;
      end
      #1;
      if (i > 0) begin
        p = i - 1;
        if (p < 16) begin
          n_cmp++;
          if ({flt_rvalid, flt_rlast, img_rvalid, flt_rdata} !== {1'b1, p == 15, 1'b0, 32'(p)}) begin
            n_bad++; $display("FAIL il_flt_beat%0d: got %h expected %h", p,
                              {flt_rvalid, flt_rlast, img_rvalid, flt_rdata}, {1'b1, p == 15, 1'b0, 32'(p)});
          end
        end else begin
          n_cmp++;
          if ({img_rvalid, img_rlast, flt_rvalid, img_rdata, flt_rdata} !==
              {1'b1, p == 31, 1'b0, 32'(p), 32'd15}) begin
            n_bad++; $display("FAIL il_img_beat%0d: got %h expected %h", p,
                              {img_rvalid, img_rlast, flt_rvalid, img_rdata, flt_rdata},
                              {1'b1, p == 31, 1'b0, 32'(p), 32'd15});
          end
        end
      end
      if (i == 20) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++; $display("FAIL il_busy_mid: got %b expected 1", busy);
        end
      end
      next_cycle();
    end
    #1;
    n_cmp++;
    if ({busy, img_rvalid, flt_rvalid, img_rdata} !== {3'b000, 32'd31}) begin
      n_bad++; $display("FAIL il_done: got %h expected %h", {busy, img_rvalid, flt_rvalid, img_rdata}, {3'b000, 32'd31});
    end
    next_cycle();
  endtask

  task automatic test_errors();
    apply_reset();
    BusArb_rvalid = 1; BusArb_rid = 4'h7; BusArb_rdata = 32'hDEAD_BEEF;
    next_cycle();
    BusArb_rvalid = 0;
    #1;
    n_cmp++;
    if ({rid_err, img_rvalid, flt_rvalid, img_rdata, flt_rdata} !== {3'b100, 64'h0}) begin
      n_bad++; $display("FAIL err_bad_rid: got %h expected %h", {rid_err, img_rvalid, flt_rvalid, img_rdata, flt_rdata},
                        {3'b100, 64'h0});
    end
    repeat (3) next_cycle();
    n_cmp++;
    if (rid_err !== 1'b1) begin
      n_bad++; $display("FAIL err_sticky: got %b expected 1", rid_err);
    end
    apply_reset();
    BusArb_rvalid = 1; BusArb_rlast = 1; BusArb_rid = 4'h1;
    next_cycle();
    BusArb_rvalid = 0; BusArb_rlast = 0;
    #1;
    n_cmp++;
    if ({rid_err, busy} !== 2'b10) begin
      n_bad++; $display("FAIL err_underflow: got rid_err,busy=%b expected 10", {rid_err, busy});
    end
    next_cycle();
    img_arvalid = 1;
    #1;
    n_cmp++;
    if (img_arready !== 1'b1) begin
      n_bad++; $display("FAIL err_cnt_zero: got arready %b expected 1", img_arready);
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_reset_in_issue();
    apply_reset();
    img_arvalid = 1; img_araddr = 28'h0ABCDEF; img_arlen = 4'd7;
    next_cycle();
    img_arvalid = 0;
    #1;
    n_cmp++;
    if ({ArbBus_arvalid, ArbBus_araddr} !== {1'b1, 28'h0ABCDEF}) begin
      n_bad++; $display("FAIL rst_pre: got %h expected %h", {ArbBus_arvalid, ArbBus_araddr}, {1'b1, 28'h0ABCDEF});
    end
    rst_n = 0;
    #1;
    n_cmp++;
    if ({ArbBus_arvalid, ArbBus_arusrid, ArbBus_arlen, ArbBus_araddr, busy} !== '0) begin
      n_bad++; $display("FAIL rst_async: got %h expected 0",
                        {ArbBus_arvalid, ArbBus_arusrid, ArbBus_arlen, ArbBus_araddr, busy});
    end
    @(posedge clk); #1 rst_n = 1;
    img_arvalid = 1; flt_arvalid = 1;
    #1;
    n_cmp++;
    if ({img_arready, flt_arready} !== 2'b10) begin
      n_bad++; $display("FAIL rst_first_tie: got %b expected 10", {img_arready, flt_arready});
    end
    clear_inputs();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_img();
    test_round_robin();
    test_outs_cap();
    test_interleaved();
    test_errors();
    test_reset_in_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
